// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder and its neighbours.
// Holds the feeder FSM encoding and the default data/address widths so the
// transmitter, receiver and feeder instantiations agree on sizes.
package uart_tx_feeder_pkg;

  localparam int D_BIT_DEF  = 8;  // data width, matches the transmitter
  localparam int ADDR_W_DEF = 4;  // FIFO address width (depth 16)

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Circular FIFO used by the feeder.
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   wr, wr_data         enqueue strobe and byte; ignored while full
//   rd                  dequeue strobe; ignored while empty
//   rd_data             head byte (combinational read of mem[rd_ptr])
//   full, empty, count  occupancy decoded from the registered count
module sync_fifo #(
  parameter int D_BIT  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr,
  input  logic [D_BIT-1:0]  wr_data,
  input  logic              rd,
  output logic [D_BIT-1:0]  rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;
  // Count is one bit wider than the pointers so full and empty are distinct.
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [D_BIT-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_ok, rd_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_ok   = wr && !full;
  assign rd_ok   = rd && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage has no reset; contents behind the pointers are never observed.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;  // wraps modulo depth
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered front end for the UART transmitter. Bytes written by the system
// are queued in a FIFO and launched one at a time: a one-cycle o_tx_start
// with o_tx_data held stable, then wait for the transmitter's i_tx_done.
// Ports:
//   i_clock, i_reset        clock, asynchronous active-high reset
//   i_wr, i_wr_data         system write strobe and byte
//   o_full, o_empty, o_count  queue occupancy (excludes the byte in flight)
//   o_overflow              one-cycle pulse when a write was dropped
//   i_tx_done               transmitter end-of-frame pulse
//   o_tx_start, o_tx_data   launch pulse and byte to the transmitter
//   o_busy                  high while a frame is in flight or bytes queued
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int D_BIT  = D_BIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [D_BIT-1:0]  i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  input  logic              i_tx_done,
  output logic              o_tx_start,
  output logic [D_BIT-1:0]  o_tx_data,
  output logic              o_busy
);

  feeder_state_t    state;
  logic             pop;
  logic [D_BIT-1:0] head;

  // Pop only from IDLE; the FIFO sees the same decision the FSM acts on.
  assign pop    = (state == IDLE) && !o_empty;
  assign o_busy = (state != IDLE) || !o_empty;

  sync_fifo #(
    .D_BIT  (D_BIT),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock   (i_clock),
    .reset   (i_reset),
    .wr      (i_wr),
    .wr_data (i_wr_data),
    .rd      (pop),
    .rd_data (head),
    .full    (o_full),
    .empty   (o_empty),
    .count   (o_count)
  );

  // o_tx_start is set on the edge entering LAUNCH, so it is high exactly
  // while state == LAUNCH. The transmitter is idle then and captures
  // o_tx_data on the LAUNCH edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_overflow <= 1'b0;
    end else begin
      // Dropped write is judged on the registered full flag, pop or not.
      o_overflow <= i_wr && o_full;
      o_tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!o_empty) begin
            o_tx_data  <= head;
            o_tx_start <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH:  state <= WAIT;
        WAIT:    if (i_tx_done) state <= IDLE;  // no timeout by design
        default: state <= IDLE;
      endcase
    end
  end

endmodule
